// File: rtl/spi_param_pkg.sv
// Shared constants, FSM state type and frame layout for the SPI parameter receiver.
package spi_param_pkg;

  localparam int unsigned CMD_W      = 8;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned CNT_W      = 5;

  localparam logic [CMD_W-1:0] CMD_YUZHI = 8'h01;
  localparam logic [CMD_W-1:0] CMD_CHSEL = 8'h02;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic [CMD_W-1:0]  cmd;
    logic [DATA_W-1:0] data;
  } frame_t;

endpackage

// File: rtl/spi_param_rx_if.sv
// SPI/vsync inputs and parameter outputs of the receiver, bundled for port connection.
interface spi_param_rx_if;
  import spi_param_pkg::*;

  logic              spi_cs;
  logic              spi_sck;
  logic              spi_mosi;
  logic              vsync;
  logic [DATA_W-1:0] yuzhi;
  logic              ch_select;
  logic              cmd_valid;
  logic              cmd_err;

  modport master (
    output spi_cs, spi_sck, spi_mosi, vsync,
    input  yuzhi, ch_select, cmd_valid, cmd_err
  );

  modport slave (
    input  spi_cs, spi_sck, spi_mosi, vsync,
    output yuzhi, ch_select, cmd_valid, cmd_err
  );
endinterface

// File: rtl/spi_param_rx_sync_edge.sv
// Two-flop synchronizer with a trailing edge register; level plus rise/fall pulses.
module sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise_c,
  output logic fall_c
);

  logic s1;
  logic s2;
  logic s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= RST_VAL;
      s2   <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1   <= d;
      s2   <= s1;
      s2_q <= s2;
    end
  end

  assign q      = s2;
  assign rise_c = s2 & ~s2_q;
  assign fall_c = ~s2 & s2_q;

endmodule

// File: rtl/spi_param_rx.sv
// SPI slave that decodes {cmd, data} frames into a Sobel threshold and a display source
// select, optionally committing the new values only at camera frame boundaries.
module spi_param_rx
  import spi_param_pkg::*;
#(
  parameter logic [DATA_W-1:0] YUZHI_RST    = 8'd60,
  parameter bit                VSYNC_COMMIT = 1'b1
) (
  input logic           sclk,
  input logic           s_rst,
  spi_param_rx_if.slave bus
);

  logic cs_lvl, cs_rise_c, cs_fall_c;
  logic sck_lvl, sck_rise_c, sck_fall_c;
  logic mosi_lvl, mosi_rise_c, mosi_fall_c;
  logic vsync_lvl, vsync_rise_c, vsync_fall_c;

  sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
    .clk(sclk), .rst(s_rst), .d(bus.spi_cs),
    .q(cs_lvl), .rise_c(cs_rise_c), .fall_c(cs_fall_c)
  );

  sync_edge #(.RST_VAL(1'b0)) u_sync_sck (
    .clk(sclk), .rst(s_rst), .d(bus.spi_sck),
    .q(sck_lvl), .rise_c(sck_rise_c), .fall_c(sck_fall_c)
  );

  sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk(sclk), .rst(s_rst), .d(bus.spi_mosi),
    .q(mosi_lvl), .rise_c(mosi_rise_c), .fall_c(mosi_fall_c)
  );

  sync_edge #(.RST_VAL(1'b0)) u_sync_vsync (
    .clk(sclk), .rst(s_rst), .d(bus.vsync),
    .q(vsync_lvl), .rise_c(vsync_rise_c), .fall_c(vsync_fall_c)
  );

  logic unused_sync;
  assign unused_sync = ^{sck_lvl, sck_fall_c, mosi_rise_c, mosi_fall_c,
                         vsync_lvl, vsync_fall_c};

  // A cs already low at reset release is only honoured after cs has been seen high.
  logic [1:0] warm;
  logic       armed;

  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) begin
      warm  <= 2'd0;
      armed <= 1'b0;
    end else begin
      if (warm != 2'd3) warm <= warm + 2'd1;
      if (warm == 2'd3 && cs_lvl) armed <= 1'b1;
    end
  end

  state_t                  state, state_nx;
  logic [CNT_W-1:0]        bit_cnt, bit_cnt_nx;
  logic [FRAME_BITS-1:0]   shreg, shreg_nx;
  logic [DATA_W-1:0]       shadow_yuzhi, shadow_yuzhi_nx;
  logic                    shadow_ch, shadow_ch_nx;
  logic [DATA_W-1:0]       yuzhi_r, yuzhi_nx;
  logic                    ch_r, ch_nx;
  logic                    cmd_valid_r, cmd_valid_nx;
  logic                    cmd_err_r, cmd_err_nx;
  logic                    decode;
  logic                    abort_err;
  frame_t                  frame;

  logic unused_msb;
  assign unused_msb = shreg[FRAME_BITS-1];

  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shreg        <= '0;
      shadow_yuzhi <= YUZHI_RST;
      shadow_ch    <= 1'b0;
      yuzhi_r      <= YUZHI_RST;
      ch_r         <= 1'b0;
      cmd_valid_r  <= 1'b0;
      cmd_err_r    <= 1'b0;
    end else begin
      state        <= state_nx;
      bit_cnt      <= bit_cnt_nx;
      shreg        <= shreg_nx;
      shadow_yuzhi <= shadow_yuzhi_nx;
      shadow_ch    <= shadow_ch_nx;
      yuzhi_r      <= yuzhi_nx;
      ch_r         <= ch_nx;
      cmd_valid_r  <= cmd_valid_nx;
      cmd_err_r    <= cmd_err_nx;
    end
  end

  always_comb begin
    state_nx        = state;
    bit_cnt_nx      = bit_cnt;
    shreg_nx        = shreg;
    shadow_yuzhi_nx = shadow_yuzhi;
    shadow_ch_nx    = shadow_ch;
    yuzhi_nx        = yuzhi_r;
    ch_nx           = ch_r;
    cmd_valid_nx    = 1'b0;
    cmd_err_nx      = 1'b0;
    decode          = 1'b0;
    abort_err       = 1'b0;
    frame           = {shreg[FRAME_BITS-2:0], mosi_lvl};

    unique case (state)
      IDLE: begin
        if (cs_fall_c && armed) begin
          state_nx   = SHIFT;
          bit_cnt_nx = '0;
          shreg_nx   = '0;
        end
      end
      SHIFT: begin
        if (cs_rise_c) begin
          state_nx   = IDLE;
          abort_err  = (bit_cnt != '0);
          bit_cnt_nx = '0;
          shreg_nx   = '0;
        end else if (sck_rise_c && !cs_lvl) begin
          shreg_nx   = {shreg[FRAME_BITS-2:0], mosi_lvl};
          bit_cnt_nx = bit_cnt + CNT_W'(1);
          if (bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
            state_nx = DONE;
            decode   = 1'b1;
          end
        end
      end
      DONE: begin
        if (cs_rise_c) begin
          state_nx   = IDLE;
          bit_cnt_nx = '0;
        end
      end
      default: state_nx = IDLE;
    endcase

    // Commit reads the registered shadows, so a same-cycle decode lands one frame later.
    if (VSYNC_COMMIT && vsync_rise_c) begin
      yuzhi_nx = shadow_yuzhi;
      ch_nx    = shadow_ch;
    end

    cmd_err_nx = abort_err;
    if (decode) begin
      if (frame.cmd == CMD_YUZHI) begin
        cmd_valid_nx    = 1'b1;
        shadow_yuzhi_nx = frame.data;
        if (!VSYNC_COMMIT) yuzhi_nx = frame.data;
      end else if (frame.cmd == CMD_CHSEL) begin
        cmd_valid_nx = 1'b1;
        shadow_ch_nx = frame.data[0];
        if (!VSYNC_COMMIT) ch_nx = frame.data[0];
      end else begin
        cmd_err_nx = 1'b1;
      end
    end
  end

  assign bus.yuzhi     = yuzhi_r;
  assign bus.ch_select = ch_r;
  assign bus.cmd_valid = cmd_valid_r;
  assign bus.cmd_err   = cmd_err_r;

endmodule

// File: tb/tb_spi_param_rx.sv
// Directed bench for spi_param_rx: one DUT with vsync commit, one with immediate update.
module tb_spi_param_rx;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   va, ea, vb, eb;
  int   pulse_bad;
  logic pv_a, pe_a, pv_b, pe_b;

  spi_param_rx_if bus_a ();
  spi_param_rx_if bus_b ();

  assign bus_b.spi_cs   = bus_a.spi_cs;
  assign bus_b.spi_sck  = bus_a.spi_sck;
  assign bus_b.spi_mosi = bus_a.spi_mosi;
  assign bus_b.vsync    = bus_a.vsync;

  spi_param_rx #(.YUZHI_RST(8'd60), .VSYNC_COMMIT(1'b1)) dut_a (
    .sclk(clk), .s_rst(rst), .bus(bus_a.slave)
  );

  spi_param_rx #(.YUZHI_RST(8'd60), .VSYNC_COMMIT(1'b0)) dut_b (
    .sclk(clk), .s_rst(rst), .bus(bus_b.slave)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Pulse counters and shape monitor for cmd_valid / cmd_err.
  initial begin
    va = 0; ea = 0; vb = 0; eb = 0; pulse_bad = 0;
    pv_a = 0; pe_a = 0; pv_b = 0; pe_b = 0;
  end

  always @(negedge clk) begin
    if (bus_a.cmd_valid === 1'b1) va++;
    if (bus_a.cmd_err   === 1'b1) ea++;
    if (bus_b.cmd_valid === 1'b1) vb++;
    if (bus_b.cmd_err   === 1'b1) eb++;
    if ((bus_a.cmd_valid && bus_a.cmd_err) || (bus_a.cmd_valid && pv_a) || (bus_a.cmd_err && pe_a))
      pulse_bad++;
    if ((bus_b.cmd_valid && bus_b.cmd_err) || (bus_b.cmd_valid && pv_b) || (bus_b.cmd_err && pe_b))
      pulse_bad++;
    pv_a = bus_a.cmd_valid; pe_a = bus_a.cmd_err;
    pv_b = bus_b.cmd_valid; pe_b = bus_b.cmd_err;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_low();
    bus_a.spi_cs = 1'b0;
    wait_cyc(4);
  endtask

  task automatic cs_high();
    wait_cyc(4);
    bus_a.spi_cs = 1'b1;
    wait_cyc(8);
  endtask

  task automatic send_bit(input logic b, input logic collide);
    bus_a.spi_mosi = b;
    wait_cyc(4);
    bus_a.spi_sck = 1'b1;
    if (collide) bus_a.vsync = 1'b1;
    wait_cyc(4);
    bus_a.spi_sck = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] val, input int n, input logic collide_last);
    cs_low();
    for (int i = n - 1; i >= 0; i--) send_bit(val[i], collide_last && (i == 0));
    cs_high();
  endtask

  // Send a frame and check how many valid/error pulses dut_a produced for it.
  task automatic frame_chk(input string tag, input logic [31:0] val, input int n,
                           input logic collide, input int exp_v, input int exp_e);
    int v0, e0;
    v0 = va; e0 = ea;
    send_bits(val, n, collide);
    chk({tag, "_valid"}, 32'(va - v0), 32'(exp_v));
    chk({tag, "_err"},   32'(ea - e0), 32'(exp_e));
  endtask

  // vsync rise: old values through the detect cycle, new values one cycle later.
  task automatic do_vsync(input string tag, input logic [7:0] y0, input logic c0,
                          input logic [7:0] y1, input logic c1);
    bus_a.vsync = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk({tag, "_y_pre"},  32'(bus_a.yuzhi),     32'(y0));
    chk({tag, "_ch_pre"}, 32'(bus_a.ch_select), 32'(c0));
    @(posedge clk); @(negedge clk);
    chk({tag, "_y_post"},  32'(bus_a.yuzhi),     32'(y1));
    chk({tag, "_ch_post"}, 32'(bus_a.ch_select), 32'(c1));
    wait_cyc(3);
    bus_a.vsync = 1'b0;
    wait_cyc(4);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v0, e0, vb0, eb0;
    total = 0; bad = 0;
    rst = 1'b1;
    bus_a.spi_cs = 1'b1; bus_a.spi_sck = 1'b0; bus_a.spi_mosi = 1'b0; bus_a.vsync = 1'b0;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(10);
    chk("rst_yuzhi",   32'(bus_a.yuzhi),     32'h3C);
    chk("rst_ch",      32'(bus_a.ch_select), 32'h0);
    chk("rst_valid",   32'(bus_a.cmd_valid), 32'h0);
    chk("rst_err",     32'(bus_a.cmd_err),   32'h0);
    chk("rst_yuzhi_b", 32'(bus_b.yuzhi),     32'h3C);

    // Normal threshold write
    frame_chk("f0180", 32'h0180, 16, 1'b0, 1, 0);
    chk("f0180_hold", 32'(bus_a.yuzhi), 32'h3C);
    chk("f0180_b",    32'(bus_b.yuzhi), 32'h80);
    do_vsync("vs0180", 8'h80 ^ 8'hBC, 1'b0, 8'h80, 1'b0);

    // Channel select on, then off
    frame_chk("f0201", 32'h0201, 16, 1'b0, 1, 0);
    chk("f0201_b", 32'(bus_b.ch_select), 32'h1);
    do_vsync("vs0201", 8'h80, 1'b0, 8'h80, 1'b1);
    frame_chk("f0200", 32'h0200, 16, 1'b0, 1, 0);
    do_vsync("vs0200", 8'h80, 1'b1, 8'h80, 1'b0);

    // Abort after 9 bits, then a good frame
    frame_chk("abort9", 32'h003, 9, 1'b0, 0, 1);
    chk("abort9_y", 32'(bus_a.yuzhi), 32'h80);
    frame_chk("f0133", 32'h0133, 16, 1'b0, 1, 0);
    do_vsync("vs0133", 8'h80, 1'b0, 8'h33, 1'b0);

    // Unknown command, then a 20-bit transfer
    frame_chk("f07ff", 32'h07FF, 16, 1'b0, 0, 1);
    chk("f07ff_b", 32'(bus_b.yuzhi), 32'h33);
    do_vsync("vs07ff", 8'h33, 1'b0, 8'h33, 1'b0);
    frame_chk("f20bit", 32'h0155A, 20, 1'b0, 1, 0);
    do_vsync("vs20bit", 8'h33, 1'b0, 8'h55, 1'b0);

    // Last write in a frame period wins
    frame_chk("f0111", 32'h0111, 16, 1'b0, 1, 0);
    frame_chk("f0122", 32'h0122, 16, 1'b0, 1, 0);
    do_vsync("vslast", 8'h55, 1'b0, 8'h22, 1'b0);

    // Decode colliding with vsync commit
    frame_chk("f0144", 32'h0144, 16, 1'b0, 1, 0);
    chk("f0144_b", 32'(bus_b.yuzhi), 32'h44);
    frame_chk("fcoll", 32'h01AA, 16, 1'b1, 1, 0);
    chk("coll_y", 32'(bus_a.yuzhi), 32'h44);
    chk("coll_b", 32'(bus_b.yuzhi), 32'hAA);
    bus_a.vsync = 1'b0;
    wait_cyc(6);
    do_vsync("vscoll", 8'h44, 1'b0, 8'hAA, 1'b0);

    // Reset in the middle of a frame
    frame_chk("f0201r", 32'h0201, 16, 1'b0, 1, 0);
    do_vsync("vs0201r", 8'hAA, 1'b0, 8'hAA, 1'b1);
    v0 = va; e0 = ea; vb0 = vb; eb0 = eb;
    cs_low();
    for (int i = 7; i >= 0; i--) send_bit(i == 0, 1'b0);
    rst = 1'b1;
    wait_cyc(2);
    rst = 1'b0;
    for (int i = 7; i >= 0; i--) send_bit(i[0], 1'b0);
    cs_high();
    chk("mrst_y",     32'(bus_a.yuzhi),     32'h3C);
    chk("mrst_ch",    32'(bus_a.ch_select), 32'h0);
    chk("mrst_err",   32'(ea - e0),         32'h0);
    chk("mrst_valid", 32'(va - v0),         32'h0);
    chk("mrst_b_y",   32'(bus_b.yuzhi),     32'h3C);
    chk("mrst_b_pul", 32'((vb - vb0) + (eb - eb0)), 32'h0);
    frame_chk("f0177", 32'h0177, 16, 1'b0, 1, 0);
    do_vsync("vs0177", 8'h3C, 1'b0, 8'h77, 1'b0);

    chk("pulse_shape", 32'(pulse_bad), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_param_rx.md
SPI_PARAM_RX -- requirements
Module: spi_param_rx

Interface
REQ-001 SHALL have parameter YUZHI_RST, default 8'd60: reset value of yuzhi.
REQ-002 SHALL have parameter VSYNC_COMMIT, default 1: 1 = outputs update only at a frame boundary; 0 = outputs update immediately after decode.
REQ-003 SHALL have port sclk, input, 1: system clock, 50 MHz; it is the only clock.
REQ-004 SHALL have port s_rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port spi_cs, input, 1: SPI chip select, active-low, asynchronous to sclk.
REQ-006 SHALL have port spi_sck, input, 1: SPI clock, mode 0, at most sclk/8.
REQ-007 SHALL have port spi_mosi, input, 1: SPI data, MSB first.
REQ-008 SHALL have port vsync, input, 1: camera frame sync; low = frame active, rising edge = frame end; asynchronous to sclk.
REQ-009 SHALL have port yuzhi, output, 8: Sobel threshold.
REQ-010 SHALL have port ch_select, output, 1: display source select; 1 = Sobel, 0 = raw.
REQ-011 SHALL have port cmd_valid, output, 1: one-cycle pulse when a legal command is decoded.
REQ-012 SHALL have port cmd_err, output, 1: one-cycle pulse when a frame is aborted or a command code is unknown.

Function
REQ-013 SHALL pass spi_cs, spi_sck, spi_mosi and vsync through 2-flop synchronizers plus one edge-detect register each.
REQ-014 SHALL sample synchronized mosi on each synchronized sck rising edge while synchronized cs is low.
REQ-015 SHALL run a FSM with three states:
  - IDLE: cs falling edge goes to SHIFT; bit counter cleared.
  - SHIFT: 16-bit shift register and 5-bit bit counter; the 16th edge goes to DONE.
  - DONE: further sck edges are ignored without error; cs rising edge goes to IDLE.
REQ-016 SHALL treat a frame as {cmd[7:0], data[7:0]}, cmd first.
REQ-017 SHALL decode in the cycle after the 16th edge, and pulse cmd_valid in that same cycle. Legal codes:
  - cmd 8'h01: shadow_yuzhi = data.
  - cmd 8'h02: shadow_ch = data[0].
REQ-018 SHALL treat any other cmd as unknown: pulse cmd_err, leave shadows unchanged.
REQ-019 SHALL, on a cs rising edge in SHIFT with bit counter 1..15, pulse cmd_err, discard the partial frame and return to IDLE.
REQ-020 SHALL, on a cs rising edge in SHIFT with bit counter 0, return to IDLE silently.
REQ-021 SHALL, when VSYNC_COMMIT=1, copy both shadows to yuzhi/ch_select on the cycle after a synchronized vsync rising edge is detected.
REQ-022 SHALL, when VSYNC_COMMIT=0, update outputs in the decode cycle, together with cmd_valid.
REQ-023 SHALL, when decode and vsync commit fall in the same cycle, commit the pre-decode shadow values; the new value commits at the next vsync.
REQ-024 SHALL, for multiple commands within one frame period, commit only the last value written per register.
REQ-025 SHALL never assert cmd_valid and cmd_err in the same cycle.
REQ-026 SHALL register all outputs; cmd_valid and cmd_err are never asserted longer than one cycle.

Reset
REQ-027 SHALL asynchronously reset on s_rst=1:
  - yuzhi = YUZHI_RST, shadow_yuzhi = YUZHI_RST.
  - ch_select = 0, shadow_ch = 0.
  - cmd_valid = 0, cmd_err = 0.
  - FSM = IDLE; counters and shift register = 0.
  - synchronizers: cs chain = 1, all others = 0.
REQ-028 SHALL, on reset during SHIFT, abort the frame without a cmd_err pulse after release.
REQ-029 SHALL ignore a transfer whose cs falling edge precedes reset release until cs goes high.

Structure
REQ-030 SHALL place in shared package spi_param_pkg:
  - CMD_YUZHI = 8'h01 and CMD_CHSEL = 8'h02.
  - FRAME_BITS = 16.
  - state enum {IDLE, SHIFT, DONE}.
REQ-031 SHALL use one sub-module, sync_edge: 2-flop synchronizer plus rise/fall pulse outputs, parameterized reset value; instantiated four times.

Verification
REQ-032 SHALL verify a normal command with VSYNC_COMMIT=1: send 16'h0180, then vsync rise -> cmd_valid one pulse; yuzhi stays 60 until vsync, then 8'h80 the cycle after the detected vsync edge.
REQ-033 SHALL verify channel select: send 16'h0201 -> ch_select 0 then 1 after vsync; send 16'h0200 -> back to 0 at the next vsync.
REQ-034 SHALL verify an aborted frame: cs high after 9 bits -> cmd_err one pulse, yuzhi unchanged; next full 16'h0133 -> yuzhi 8'h33 after vsync.
REQ-035 SHALL verify an unknown command and extra bits: send 16'h07FF -> cmd_err, no change; 20 bits starting 16'h0155 -> yuzhi 8'h55, no error.
REQ-036 SHALL verify a decode/vsync collision: decode 16'h01AA in the same cycle as the vsync commit -> yuzhi keeps its old value, becomes 8'hAA at the next vsync.
REQ-037 SHALL verify reset mid-frame: assert s_rst after 8 bits -> yuzhi=60, ch_select=0, no cmd_err after release.
